branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch sequencer that feeds and consumes the condition flip-flop. On a start pulse it captures a conditional-branch instruction and PC, and drives the tested register onto the bus with the condition code and latch enable. One cycle later it reads the latched condition result and either loads PC with PC + sign-extended displacement or leaves PC untouched. It sits in the control path between instruction decode and the PC register, replacing hand-sequenced branch control steps.

## Interface
Parameters:
- DISP_W, 19, displacement width taken from ir[DISP_W-1:0], sign-extended to 32 bits

Ports:
- clock  input  1  system clock, rising edge
- clear  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to execute the branch in ir
- ir  input  32  instruction: Ra = ir[26:23], condition code = ir[20:19], displacement = ir[DISP_W-1:0]
- pc_in  input  32  PC value to branch relative to (already incremented)
- cond_in  input  1  registered condition result from the condition flip-flop
- stats_clr  input  1  synchronous clear of statistics counters
- busy  output  1  high while a branch is in flight
- reg_sel  output  4  register index to drive onto the bus (Ra)
- reg_out  output  1  enable for the selected register onto the bus
- c2  output  2  condition code to the condition flip-flop: 00 zero, 01 nonzero, 10 positive, 11 negative
- con_in  output  1  latch enable to the condition flip-flop
- pc_load  output  1  one-cycle load strobe for PC
- pc_next  output  32  branch target
- done  output  1  one-cycle completion pulse
- taken  output  1  outcome of the last branch, valid from done until the next start
- branch_count  output  16  branches completed
- taken_count  output  16  branches taken

## Operation
- Three-state FSM: IDLE, EVAL, RESOLVE.
- IDLE: when start=1, capture ir fields and pc_in into internal registers, then go to EVAL.
- EVAL (one cycle): reg_out=1, reg_sel=captured Ra, c2=captured condition code, con_in=1. The condition flip-flop latches at the end of this cycle. Go to RESOLVE.
- RESOLVE (one cycle): sample cond_in; done=1 and taken=cond_in.
  - If cond_in=1: pc_load=1.
  - pc_next = pc_q + sext(disp) on every RESOLVE cycle, modulo 2^32; wrap-around is silent.
  - Go to IDLE.
- busy=1 in EVAL and RESOLVE.
- start while busy is ignored; no queueing.
- start in the same cycle RESOLVE returns to IDLE is ignored; a new branch needs start in IDLE.
- All strobe outputs (reg_out, con_in, pc_load, done) are pure decodes of state and captured data; they are 0 in IDLE.
- reg_sel, c2 and pc_next hold their captured values in IDLE.

## Timing
- start sampled at edge N; EVAL is cycle N+1; RESOLVE is cycle N+2; idle again at N+3. Fixed latency: 2 cycles from start to done.
- cond_in is sampled only in RESOLVE. It must be the flip-flop output updated at the edge ending EVAL.
- Reset values: state IDLE; busy, reg_out, con_in, pc_load, done, taken = 0; reg_sel, c2 = 0; pc_next = 0; counters = 0.
- clear mid-operation returns to IDLE immediately. A branch aborted in EVAL or RESOLVE produces no pc_load and no done.
- Minimum branch-to-branch spacing: 3 cycles.

## Configuration
- BRANCH_STATS_EN defined: branch_count increments on every done; taken_count increments on done with taken=1.
  - Both counters saturate at 16'hFFFF.
  - stats_clr=1 zeroes both counters on the next edge and takes priority over an increment in the same cycle.
- BRANCH_STATS_EN undefined: both ports remain and are tied to 0; stats_clr is ignored; no counter flops are inferred.

## Test plan
- brzr taken: ir c2=00, Ra=3, disp=0x00010, pc_in=0x100, cond_in=1 in RESOLVE -> reg_sel=3, con_in at N+1; pc_load, done, taken=1, pc_next=0x110 at N+2.
- brnz backward: c2=01, disp=0x7FFFC (-4), pc_in=0x100, cond_in=1 -> pc_next=0xFC, pc_load=1.
- brmi not taken: c2=11, cond_in=0 -> done=1, taken=0, pc_load=0 at N+2; pc_next still computed.
- Wrap and overlap: pc_in=0xFFFFFFF8, disp=+16, taken -> pc_next=0x00000008. A second start at N+1 is ignored; only one done.
- clear asserted during EVAL -> busy=0 immediately; no pc_load or done follows; next start completes normally.
- With BRANCH_STATS_EN: 3 branches (2 taken) -> branch_count=3, taken_count=2. stats_clr in the same cycle as a done -> both 0. Without the macro -> both always 0.

Source files
------------

// File: rtl/branch_ctrl.sv
// Conditional-branch sequencer: captures ir/pc on start, drives the condition flip-flop,
// then resolves the PC load. Define BRANCH_STATS_EN to enable the saturating branch/taken counters.
//   state   | meaning
//   IDLE    | waiting for start, captured fields held on reg_sel/c2/pc_next
//   EVAL    | Ra on bus, condition flip-flop latches at end of cycle
//   RESOLVE | cond_in sampled, done pulse, pc_load when taken
module branch_ctrl #(
  parameter int DISP_W = 19
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic [31:0] pc_in,
  input  logic        cond_in,
  input  logic        stats_clr,
  output logic        busy,
  output logic [3:0]  reg_sel,
  output logic        reg_out,
  output logic [1:0]  c2,
  output logic        con_in,
  output logic        pc_load,
  output logic [31:0] pc_next,
  output logic        done,
  output logic        taken,
  output logic [15:0] branch_count,
  output logic [15:0] taken_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, RESOLVE = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [3:0]          ra_q, ra_d;
  logic [1:0]          cc_q, cc_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic [31:0]         pc_q, pc_d;
  logic                taken_q, taken_d;

  logic unused_ir;
  assign unused_ir = ^{ir[31:27], ir[22:21]};

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      ra_q    <= '0;
      cc_q    <= '0;
      disp_q  <= '0;
      pc_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      cc_q    <= cc_d;
      disp_q  <= disp_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = EVAL;
      EVAL:    state_d = RESOLVE;
      RESOLVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture only from IDLE; start while busy or on the RESOLVE->IDLE edge is dropped.
  always_comb begin
    ra_d    = ra_q;
    cc_d    = cc_q;
    disp_d  = disp_q;
    pc_d    = pc_q;
    taken_d = taken_q;
    if (state_q == IDLE && start) begin
      ra_d   = ir[26:23];
      cc_d   = ir[20:19];
      disp_d = ir[DISP_W-1:0];
      pc_d   = pc_in;
    end
    if (state_q == RESOLVE) taken_d = cond_in;
  end

  always_comb begin
    busy    = (state_q != IDLE);
    reg_out = (state_q == EVAL);
    con_in  = (state_q == EVAL);
    done    = (state_q == RESOLVE);
    pc_load = (state_q == RESOLVE) && cond_in;
    taken   = (state_q == RESOLVE) ? cond_in : taken_q;
  end

  assign reg_sel = ra_q;
  assign c2      = cc_q;
  assign pc_next = pc_q + {{(32-DISP_W){disp_q[DISP_W-1]}}, disp_q};

`ifdef BRANCH_STATS_EN
  logic [15:0] bcnt_q, bcnt_d;
  logic [15:0] tcnt_q, tcnt_d;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      bcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      tcnt_q <= tcnt_d;
    end
  end

  // stats_clr wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    bcnt_d = bcnt_q;
    tcnt_d = tcnt_q;
    if (stats_clr) begin
      bcnt_d = '0;
      tcnt_d = '0;
    end else if (done) begin
      if (bcnt_q != 16'hFFFF) bcnt_d = bcnt_q + 16'd1;
      if (cond_in && tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
    end
  end

  assign branch_count = bcnt_q;
  assign taken_count  = tcnt_q;
`else
  logic unused_stats;
  assign unused_stats = stats_clr;
  assign branch_count = '0;
  assign taken_count  = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed spec scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_branch_ctrl;
  localparam int DISP_W = 19;

  logic        clock = 1'b0;
  logic        clear, start, cond_in, stats_clr;
  logic [31:0] ir, pc_in;
  logic        busy, reg_out, con_in, pc_load, done, taken;
  logic [3:0]  reg_sel;
  logic [1:0]  c2;
  logic [31:0] pc_next;
  logic [15:0] branch_count, taken_count;

  branch_ctrl #(.DISP_W(DISP_W)) dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .pc_in(pc_in),
    .cond_in(cond_in), .stats_clr(stats_clr), .busy(busy), .reg_sel(reg_sel),
    .reg_out(reg_out), .c2(c2), .con_in(con_in), .pc_load(pc_load),
    .pc_next(pc_next), .done(done), .taken(taken),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: age = cycles since an accepted start (1 = eval, 2 = resolve, -1 = none)
  int          age;
  logic [3:0]  m_ra;
  logic [1:0]  m_cc;
  logic [31:0] m_disp;
  logic [31:0] m_pc;
  logic        m_taken;
  int          m_bc, m_tc;
  int          dones;
  int          cond_mode = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_ir(input int ra, input int cc, input int disp);
    logic [31:0] v;
    v = 32'((ra & 15) * (1 << 23)) + 32'((cc & 3) * (1 << 19)) + 32'(disp % (1 << DISP_W));
    return v;
  endfunction

  function automatic logic [31:0] sext_val(input logic [31:0] d);
    logic [31:0] v;
    v = d;
    if (d >= 32'(1 << (DISP_W - 1))) v = d - 32'(1 << DISP_W);
    return v;
  endfunction

  task automatic model_reset();
    age = -1; m_ra = 0; m_cc = 0; m_disp = 0; m_pc = 0; m_taken = 0;
    m_bc = 0; m_tc = 0;
  endtask

  task automatic check_outputs();
    int exp_bc, exp_tc;
`ifdef BRANCH_STATS_EN
    exp_bc = m_bc; exp_tc = m_tc;
`else
    exp_bc = 0; exp_tc = 0;
`endif
    chk("busy",    busy,    32'(age > 0));
    chk("reg_out", reg_out, 32'(age == 1));
    chk("con_in",  con_in,  32'(age == 1));
    chk("reg_sel", reg_sel, m_ra);
    chk("c2",      c2,      m_cc);
    chk("done",    done,    32'(age == 2));
    chk("pc_load", pc_load, 32'(age == 2 && cond_in));
    chk("taken",   taken,   (age == 2) ? 32'(cond_in) : 32'(m_taken));
    chk("pc_next", pc_next, m_pc + sext_val(m_disp));
    chk("branch_count", branch_count, 32'(exp_bc));
    chk("taken_count",  taken_count,  32'(exp_tc));
  endtask

  task automatic tick();
    if (age == 2) begin
      m_taken = cond_in;
      dones++;
    end
    if (stats_clr) begin
      m_bc = 0; m_tc = 0;
    end else if (age == 2) begin
      if (m_bc < 65535) m_bc++;
      if (cond_in && m_tc < 65535) m_tc++;
    end
    if (age == 1) age = 2;
    else if (age == 2) age = -1;
    else if (start) begin
      m_ra = ir[26:23]; m_cc = ir[20:19]; m_disp = 32'(ir[DISP_W-1:0]); m_pc = pc_in; age = 1;
    end
    @(posedge clock);
    #1;
    cond_in = (cond_mode < 0) ? 1'($urandom % 2) : cond_mode[0];
    #1;
    check_outputs();
    start = 0;
    stats_clr = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    #1;
    model_reset();
    check_outputs();
    clear = 0;
  endtask

  initial begin
    int d0;
    clear = 1; start = 0; ir = 0; pc_in = 0; cond_in = 0; stats_clr = 0;
    dones = 0;
    model_reset();
    #12;
    check_outputs();
    clear = 0;

    // brzr taken, forward
    ir = mk_ir(3, 0, 32'h10); pc_in = 32'h100; start = 1; cond_mode = 1;
    tick();
    chk("t1_reg_sel", reg_sel, 3);
    tick();
    chk("t1_pc_next", pc_next, 32'h110);
    chk("t1_pc_load", pc_load, 1);
    tick();

    // brnz backward
    ir = mk_ir(5, 1, 32'h7FFFC); pc_in = 32'h100; start = 1;
    tick(); tick();
    chk("t2_pc_next", pc_next, 32'hFC);
    tick();

    // brmi not taken
    ir = mk_ir(2, 3, 32'h20); pc_in = 32'h400; start = 1; cond_mode = 0;
    tick(); tick();
    chk("t3_done", done, 1);
    chk("t3_pc_load", pc_load, 0);
    chk("t3_pc_next", pc_next, 32'h420);
    tick();

    // wrap-around with an overlapping start that must be dropped
    d0 = dones;
    ir = mk_ir(7, 2, 16); pc_in = 32'hFFFFFFF8; start = 1; cond_mode = 1;
    tick();
    ir = mk_ir(9, 1, 100); pc_in = 32'h5000; start = 1;
    tick();
    chk("t4_pc_next", pc_next, 32'h8);
    start = 1;
    tick();
    tick(); tick(); tick();
    chk("t4_one_done", 32'(dones - d0), 1);

    // clear during EVAL aborts the branch
    ir = mk_ir(4, 0, 8); pc_in = 32'h200; start = 1; cond_mode = -1;
    tick();
    do_clear();
    chk("t5_busy", busy, 0);
    tick(); tick();
    ir = mk_ir(6, 1, 4); pc_in = 32'h300; start = 1;
    tick(); tick();
    chk("t5_done", done, 1);
    tick();

    // statistics: 3 branches, 2 taken
    stats_clr = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      ir = mk_ir(i, i, i * 4); pc_in = 32'h1000; start = 1; cond_mode = (i == 1) ? 0 : 1;
      tick(); tick(); tick();
    end
`ifdef BRANCH_STATS_EN
    chk("t6_branch_count", branch_count, 3);
    chk("t6_taken_count",  taken_count,  2);
`else
    chk("t6_branch_count", branch_count, 0);
    chk("t6_taken_count",  taken_count,  0);
`endif
    ir = mk_ir(1, 1, 1); start = 1; cond_mode = 1;
    tick(); tick();
    stats_clr = 1;
    tick();
    chk("t7_branch_count", branch_count, 0);
    chk("t7_taken_count",  taken_count,  0);

    // randomized traffic
    cond_mode = -1;
    for (int i = 0; i < 400; i++) begin
      ir = $urandom; pc_in = $urandom;
      start = 1'($urandom % 2);
      stats_clr = ($urandom % 20) == 0;
      if (($urandom % 60) == 0) do_clear();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
